instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/simd_pkg.sv | 35 +++
 rtl/instr_sequencer.sv | 151 +++++++++++++++
 tb/tb_instr_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared opcode/state types and helpers for the SIMD instruction sequencer
//
// Purpose: opcode and sequencer-state enums, opcode field position, and the
//          opcode legality check used by instr_sequencer.
// Ports:   none (package).

package simd_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 2;

  typedef enum logic [2:0] {
    OP_LOADA   = 3'b010,
    OP_LOADB   = 3'b011,
    OP_MULTACC = 3'b100,
    OP_STORE   = 3'b101,
    OP_STOP    = 3'b110
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_e;

  // STOP counts as legal: it is a valid program terminator, just never issued.
  function automatic logic is_legal_opcode(input logic [2:0] i_op);
    case (i_op)
      OP_LOADA, OP_LOADB, OP_MULTACC, OP_STORE, OP_STOP: is_legal_opcode = 1'b1;
      default:                                          is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches instructions from a store and issues them to a SIMD datapath
//
// Purpose: runs a program from START_ADDR on START, fetching one word per
//          FETCH cycle and holding it in ISSUE until the datapath accepts it.
//          Stops on a STOP opcode (DONE pulse); faults on an illegal opcode or
//          on running past the last store word without a STOP.
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   START        single-cycle run request (honoured in IDLE and FAULT)
//   PC_AXI       instruction store read address (the PC register)
//   INSTR_AXI    instruction word for PC_AXI, combinational
//   INSTR_OUT    instruction held for the datapath
//   INSTR_VALID  INSTR_OUT is valid (ISSUE only)
//   INSTR_READY  datapath accepts INSTR_OUT
//   BUSY         high in FETCH and ISSUE
//   DONE         one-cycle pulse after STOP is fetched
//   ERROR        sticky fault flag, cleared by START
//   INSTR_COUNT  instructions accepted since START, saturating

module instr_sequencer
  import simd_pkg::*;
#(
  parameter int N          = 512,
  parameter int START_ADDR = 0
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 START,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] PC_AXI,
  input  logic [31:0]                          INSTR_AXI,
  output logic [31:0]                          INSTR_OUT,
  output logic                                 INSTR_VALID,
  input  logic                                 INSTR_READY,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 ERROR,
  output logic [15:0]                          INSTR_COUNT
);

  localparam int              PC_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(N - 1);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [15:0]     r_count;
  logic            r_done;
  logic            r_error;

  logic [2:0]      w_opcode;
  logic            w_restart;
  logic            w_load_instr;
  logic            w_advance;
  logic            w_set_done;
  logic            w_set_error;

  assign w_opcode = INSTR_AXI[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_restart    = 1'b0;
    w_load_instr = 1'b0;
    w_advance    = 1'b0;
    w_set_done   = 1'b0;
    w_set_error  = 1'b0;
    case (r_state)
      ST_IDLE, ST_FAULT: begin
        if (START) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!is_legal_opcode(w_opcode)) begin
          w_set_error = 1'b1;
          w_state_nxt = ST_FAULT;
        end else if (w_opcode == OP_STOP) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load_instr = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (INSTR_READY) begin
          w_advance = 1'b1;
          // Accepting the last store word without having seen STOP would
          // make the PC wrap into unrelated code, so treat it as a fault.
          if (r_pc == PC_LAST) begin
            w_set_error = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc    <= PC_START;
      r_instr <= 32'd0;
      r_count <= 16'd0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= w_set_done;
      if (w_restart) begin
        r_pc    <= PC_START;
        r_count <= 16'd0;
        r_error <= 1'b0;
      end
      if (w_load_instr) begin
        r_instr <= INSTR_AXI;
      end
      if (w_advance) begin
        r_pc <= r_pc + 1'b1;
        if (r_count != 16'hFFFF) begin
          r_count <= r_count + 16'd1;
        end
      end
      if (w_set_error) begin
        r_error <= 1'b1;
      end
    end
  end

  // Valid/busy decode straight from state so an async reset drops them at once.
  assign PC_AXI      = r_pc;
  assign INSTR_OUT   = r_instr;
  assign INSTR_VALID = (r_state == ST_ISSUE);
  assign BUSY        = (r_state == ST_FETCH) || (r_state == ST_ISSUE);
  assign DONE        = r_done;
  assign ERROR       = r_error;
  assign INSTR_COUNT = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer

module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ready;
  logic [8:0]  pc;
  logic [31:0] instr_axi, instr_out;
  logic        valid, busy, done, error;
  logic [15:0] cnt;

  logic        start16, ready16;
  logic [3:0]  pc16;
  logic [31:0] instr_axi16, instr_out16;
  logic        valid16, busy16, done16, error16;
  logic [15:0] cnt16;

  logic [31:0] mem   [0:511];
  logic [31:0] mem16 [0:15];

  int total = 0;
  int bad   = 0;

  logic [31:0] issued[$];
  int          hs_cyc[$];
  int          done_cnt;
  logic [8:0]  done_pc;

  always #5 clk = ~clk;

  assign instr_axi   = mem[pc];
  assign instr_axi16 = mem16[pc16];

  instr_sequencer #(.N(512), .START_ADDR(0)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .PC_AXI(pc), .INSTR_AXI(instr_axi),
    .INSTR_OUT(instr_out), .INSTR_VALID(valid), .INSTR_READY(ready),
    .BUSY(busy), .DONE(done), .ERROR(error), .INSTR_COUNT(cnt)
  );

  instr_sequencer #(.N(16), .START_ADDR(0)) u_dut16 (
    .CLK(clk), .RST(rst), .START(start16), .PC_AXI(pc16), .INSTR_AXI(instr_axi16),
    .INSTR_OUT(instr_out16), .INSTR_VALID(valid16), .INSTR_READY(ready16),
    .BUSY(busy16), .DONE(done16), .ERROR(error16), .INSTR_COUNT(cnt16)
  );

  // Word i: index in bits [15:8], opcode cycling LOADA, LOADB, MULTACC, STORE.
  function automatic logic [31:0] prog_word(input int i);
    logic [2:0] op;
    case (i % 4)
      0:       op = 3'b010;
      1:       op = 3'b011;
      2:       op = 3'b100;
      default: op = 3'b101;
    endcase
    return (32'(i) << 8) | {29'd0, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0006;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = prog_word(i);
      mem16[i] = prog_word(i);
    end
  endtask

  task automatic run_cycles(input int n);
    issued.delete();
    hs_cyc.delete();
    done_cnt = 0;
    done_pc  = '1;
    for (int c = 0; c < n; c++) begin
      if (valid && ready) begin
        issued.push_back(instr_out);
        hs_cyc.push_back(c);
      end
      if (done) begin
        done_cnt++;
        done_pc = pc;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", error); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if (instr_out !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++; if (valid16 !== 1'b0 || busy16 !== 1'b0) begin bad++; $display("FAIL reset_dut16 valid=%0b busy=%0b exp=0", valid16, busy16); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_start busy got=%0b exp=0", busy); end
  endtask

  task automatic test_program();
    pulse_start();
    total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL prog_fetch busy=%0b valid=%0b exp busy=1 valid=0", busy, valid); end
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL prog_start_pc got=%0d exp=0", pc); end
    tick();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL prog_first_valid got=%0b exp=1", valid); end
    total++; if (instr_out !== 32'h0000_0002) begin bad++; $display("FAIL prog_first_instr got=%h exp=00000002", instr_out); end
    run_cycles(60);
    total++; if (issued.size() != 16) begin bad++; $display("FAIL prog_handshakes got=%0d exp=16", issued.size()); end
    for (int i = 0; i < issued.size() && i < 16; i++) begin
      total++; if (issued[i] !== prog_word(i)) begin bad++; $display("FAIL prog_word%0d got=%h exp=%h", i, issued[i], prog_word(i)); end
    end
    if (hs_cyc.size() == 16) begin
      total++; if (hs_cyc[15] - hs_cyc[0] != 30) begin bad++; $display("FAIL prog_rate got=%0d exp=30", hs_cyc[15] - hs_cyc[0]); end
    end
    total++; if (cnt !== 16'd16) begin bad++; $display("FAIL prog_count got=%0d exp=16", cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL prog_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (done_pc !== 9'd16) begin bad++; $display("FAIL prog_done_pc got=%0d exp=16", done_pc); end
    total++; if (error !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL prog_end error=%0b busy=%0b exp=0", error, busy); end
  endtask

  task automatic test_backpressure();
    int stall = 0;
    int held  = 0;
    issued.delete();
    done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 80; c++) begin
      if (valid && pc == 9'd2) begin
        held++;
        total++; if (instr_out !== 32'h0000_0204) begin bad++; $display("FAIL bp_hold_instr got=%h exp=00000204", instr_out); end
        if (stall < 5) begin
          ready = 1'b0;
          stall++;
        end else begin
          ready = 1'b1;
        end
      end else begin
        ready = 1'b1;
      end
      if (valid && ready) issued.push_back(instr_out);
      if (done) done_cnt++;
      tick();
    end
    ready = 1'b1;
    total++; if (held != 6) begin bad++; $display("FAIL bp_valid_cycles_at_pc2 got=%0d exp=6", held); end
    total++; if (issued.size() != 16) begin bad++; $display("FAIL bp_handshakes got=%0d exp=16", issued.size()); end
    if (issued.size() > 3) begin
      total++; if (issued[3] !== 32'h0000_0305) begin bad++; $display("FAIL bp_resume_instr got=%h exp=00000305", issued[3]); end
    end
    total++; if (cnt !== 16'd16 || done_cnt != 1) begin bad++; $display("FAIL bp_end count=%0d done=%0d exp 16/1", cnt, done_cnt); end
  endtask

  task automatic test_illegal();
    mem[3] = 32'h0000_0007;
    pulse_start();
    run_cycles(30);
    total++; if (issued.size() != 3) begin bad++; $display("FAIL ill_handshakes got=%0d exp=3", issued.size()); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ill_error got=%0b exp=1", error); end
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL ill_fault busy=%0b valid=%0b exp=0", busy, valid); end
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL ill_count got=%0d exp=3", cnt); end
    mem[3] = prog_word(3);
    pulse_start();
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ill_restart error=%0b busy=%0b exp 0/1", error, busy); end
    total++; if (cnt !== 16'd0 || pc !== 9'd0) begin bad++; $display("FAIL ill_restart_clear count=%0d pc=%0d exp 0/0", cnt, pc); end
    run_cycles(60);
    total++; if (done_cnt != 1 || cnt !== 16'd16) begin bad++; $display("FAIL ill_rerun done=%0d count=%0d exp 1/16", done_cnt, cnt); end
  endtask

  task automatic test_wrap();
    int hs = 0;
    int dn = 0;
    ready16 = 1'b1;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (valid16 && ready16) hs++;
      if (done16) dn++;
      tick();
    end
    total++; if (hs != 16) begin bad++; $display("FAIL wrap_handshakes got=%0d exp=16", hs); end
    total++; if (error16 !== 1'b1) begin bad++; $display("FAIL wrap_error got=%0b exp=1", error16); end
    total++; if (busy16 !== 1'b0 || valid16 !== 1'b0) begin bad++; $display("FAIL wrap_fault busy=%0b valid=%0b exp=0", busy16, valid16); end
    total++; if (cnt16 !== 16'd16 || dn != 0) begin bad++; $display("FAIL wrap_count count=%0d done=%0d exp 16/0", cnt16, dn); end
  endtask

  task automatic test_reset_mid_issue();
    int c = 0;
    pulse_start();
    while (!(valid && pc == 9'd5) && c < 40) begin
      tick();
      c++;
    end
    total++; if (!(valid && pc == 9'd5)) begin bad++; $display("FAIL rst_wait_word5 valid=%0b pc=%0d exp 1/5", valid, pc); end
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_mid_flags valid=%0b busy=%0b done=%0b error=%0b exp=0", valid, busy, done, error); end
    total++; if (cnt !== 16'd0 || instr_out !== 32'd0 || pc !== 9'd0) begin bad++; $display("FAIL rst_mid_regs count=%0d instr=%h pc=%0d exp=0", cnt, instr_out, pc); end
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    pulse_start();
    total++; if (pc !== 9'd0 || busy !== 1'b1) begin bad++; $display("FAIL rst_restart pc=%0d busy=%0b exp 0/1", pc, busy); end
    tick();
    total++; if (valid !== 1'b1 || instr_out !== 32'h0000_0002) begin bad++; $display("FAIL rst_restart_issue valid=%0b instr=%h exp 1/00000002", valid, instr_out); end
    run_cycles(60);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rst_rerun_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_during_issue();
    int c = 0;
    pulse_start();
    while (!(valid && pc == 9'd4) && c < 40) begin
      tick();
      c++;
    end
    total++; if (cnt !== 16'd4) begin bad++; $display("FAIL sdi_count_before got=%0d exp=4", cnt); end
    pulse_start();
    total++; if (pc !== 9'd5 || cnt !== 16'd5) begin bad++; $display("FAIL sdi_continue pc=%0d count=%0d exp 5/5", pc, cnt); end
    total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL sdi_fetch busy=%0b valid=%0b exp 1/0", busy, valid); end
    run_cycles(60);
    total++; if (issued.size() != 11) begin bad++; $display("FAIL sdi_remaining got=%0d exp=11", issued.size()); end
    total++; if (cnt !== 16'd16 || done_cnt != 1) begin bad++; $display("FAIL sdi_end count=%0d done=%0d exp 16/1", cnt, done_cnt); end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ready   = 1'b1;
    start16 = 1'b0;
    ready16 = 1'b1;
    load_prog();
    test_reset();
    test_program();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid_issue();
    test_start_during_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
